// File: rtl/flit_sender.sv
// Output-port flit sender: requests a route, then streams header, size and payload flits under credit flow control.
// Optional packet statistics counter enabled by defining FLIT_SENDER_STATS_EN.
`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif
`ifndef TAM_BUFFER
`define TAM_BUFFER 16
`endif

module flit_sender #(
  parameter int WIDTH = `TAM_FLIT,
  parameter int DEPTH = `TAM_BUFFER
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       head,
  input  logic [$clog2(DEPTH):0] count,
  output logic                   pull,
  output logic                   h,
  input  logic                   ack_h,
  output logic                   tx,
  output logic [WIDTH-1:0]       data_out,
  input  logic                   credit_i,
  output logic                   sender_free
`ifdef FLIT_SENDER_STATS_EN
  ,
  output logic [15:0]            pkt_count
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, HDR, SIZE, PAYLOAD} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] remaining, remaining_next;
  logic             has_flit;
  logic             sending;

  assign has_flit = (count != '0);
  assign sending  = (state == HDR) || (state == SIZE) || (state == PAYLOAD);
  assign tx       = sending && has_flit;
  assign pull     = tx && credit_i;
  assign data_out = head;

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep every register update ordered as a true edge-triggered flop.
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next     = state;
    remaining_next = remaining;
    h              = 1'b0;
    sender_free    = 1'b0;
    case (state)
      IDLE: if (has_flit) state_next = REQ;
      REQ: begin
        h = 1'b1;
        if (ack_h) state_next = HDR;
      end
      HDR: if (pull) state_next = SIZE;
      SIZE: begin
        if (pull) begin
          remaining_next = head;
          if (head == '0) begin
            state_next  = IDLE;
            sender_free = 1'b1;
          end else begin
            state_next = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (pull) begin
          remaining_next = remaining - 1'b1;
          // The flit that consumes the last unit of size closes the packet.
          if (remaining == WIDTH'(1)) begin
            state_next  = IDLE;
            sender_free = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef FLIT_SENDER_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      pkt_count <= '0;
    end else if (sender_free && (pkt_count != 16'hFFFF)) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end
`endif

endmodule
